// File: rtl/seq_divider_32.sv
// seq_divider_32: multicycle signed divider, restoring shift-and-subtract,
// one quotient bit per clock. Operands are converted to magnitudes on accept,
// iterated unsigned, and signs are re-applied in the DONE state.
//
// Optional build macro:
//   SEQ_DIV_EARLY_EXIT_EN - when defined, an operation with a non-zero divisor
//                           and |dividend| < |divisor| bypasses RUN entirely
//                           (quotient 0, remainder = dividend). Results are
//                           identical with or without it; only latency changes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for ctrl_div; last result held on the outputs
// RUN   | WIDTH iterations of shift / trial-subtract / restore
// DONE  | apply signs, register outputs, pulse result_rdy

module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH:0]     dvs_mag_q;
    logic               sign_dvd_q;
    logic               sign_dvs_q;
    logic               div_zero_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     dvd_mag;
    logic [WIDTH:0]     dvs_mag;
    logic               dvs_zero;
    logic               accept;
    logic               early_exit;
    logic               skip_run;
    logic               last_iter;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;
    logic [WIDTH-1:0]   q_signed;
    logic [WIDTH-1:0]   r_signed;
    logic               unused_bits;

    // Operand magnitudes use one extra bit so that |-2^(WIDTH-1)| is representable.
    assign dvd_mag  = dividend[WIDTH-1] ? -{dividend[WIDTH-1], dividend}
                                        :  {1'b0, dividend};
    assign dvs_mag  = divisor[WIDTH-1]  ? -{divisor[WIDTH-1], divisor}
                                        :  {1'b0, divisor};
    assign dvs_zero = (divisor == '0);

    // A start in the result_rdy cycle is dropped: busy is still high there.
    assign accept   = (state == S_IDLE) && ctrl_div && !result_rdy;

`ifdef SEQ_DIV_EARLY_EXIT_EN
    assign early_exit = !dvs_zero && (dvd_mag < dvs_mag);
`else
    assign early_exit = 1'b0;
`endif

    assign skip_run  = dvs_zero || early_exit;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Restoring step: partial remainder is always below |divisor| <= 2^(WIDTH-1),
    // so the shifted value fits in WIDTH+1 bits and the kept difference in WIDTH.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, dvs_mag_q};
    assign trial_ok  = !trial[WIDTH+1];

    // Sign application; wrap of -2^(WIDTH-1) / -1 falls out naturally.
    assign q_signed = (sign_dvd_q ^ sign_dvs_q) ? -quo_q : quo_q;
    assign r_signed = sign_dvd_q ? -rem_q : rem_q;

    assign unused_bits = ^{trial[WIDTH], dvd_mag[WIDTH]};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = skip_run ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // busy covers RUN, DONE and the result_rdy cycle that follows DONE.
    always_comb begin
        busy = 1'b0;
        if ((state == S_RUN) || (state == S_DONE) || result_rdy) begin
            busy = 1'b1;
        end
    end

    // Datapath, iteration counter and registered results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_mag_q  <= '0;
            sign_dvd_q <= 1'b0;
            sign_dvs_q <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            quotient   <= '0;
            remainder  <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_dvd_q <= dividend[WIDTH-1];
                        sign_dvs_q <= divisor[WIDTH-1];
                        div_zero_q <= dvs_zero;
                        dvs_mag_q  <= dvs_mag;
                        cnt_q      <= '0;
                        if (skip_run) begin
                            rem_q <= dvd_mag[WIDTH-1:0];
                            quo_q <= '0;
                        end else begin
                            rem_q <= '0;
                            quo_q <= dvd_mag[WIDTH-1:0];
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], trial_ok};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    quotient   <= q_signed;
                    remainder  <= r_signed;
                    exception  <= div_zero_q;
                    result_rdy <= 1'b1;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
